serial_twos_complementer: RTL and testbench
===========================================

// Module: serial_twos_complementer
// PURPOSE
//  Bit-serial two's-complement stage that feeds the async-reset D flip-flop output register.
//  - Input: LSB-first serial word. Output: its two's complement (-x mod 2^WIDTH), also
//    LSB-first, one bit per accepted input bit.
//  - Method: pass bits unchanged up to and including the first 1; invert every later bit.
// PARAMETERS
//  WIDTH   8   word length in bits; legal range 2..256
// PORTS
//  clk        in   1  clock; all state changes on the rising edge
//  reset      in   1  asynchronous, active-high; clears all state immediately
//  start      in   1  first bit (LSB) of a new word is on data; legal only with data_valid=1
//  data_valid in   1  data carries a valid bit this cycle (0 = stall, bit not consumed)
//  data       in   1  serial input bit
//  q          out  1  serial result bit, registered
//  q_valid    out  1  q holds a new result bit this cycle
//  done       out  1  1-cycle pulse, aligned with q_valid on the result MSB
//  busy       out  1  a word is in progress (after start, before the last bit is accepted)
//  ovf        out  1  [COMPL_OVF_DETECT_EN only] asserted together with done
// BEHAVIOUR
//  - Reset values: q=0, q_valid=0, done=0, busy=0, ovf=0; state=IDLE, bit counter=0.
//  - States:
//    - IDLE: waiting for start.
//    - PASS: no 1 seen yet in the word; output bit = input bit.
//    - INV: a 1 has been seen; output bit = ~input bit.
//  - Bit acceptance:
//    - A bit is accepted on an edge where data_valid=1 and either
//      (IDLE and start=1) or (PASS/INV and the word is not yet complete).
//  - IDLE transitions:
//    - On an accepted start bit: q<=data, counter<=1, q_valid<=1.
//    - Next state: INV if data=1, else PASS.
//  - PASS transitions:
//    - On an accepted bit: q<=data, counter+1.
//    - Next state: INV if data=1, else stay in PASS.
//  - INV transitions:
//    - On an accepted bit: q<=~data, counter+1.
//  - Last bit:
//    - The WIDTH-th accepted bit returns the FSM to IDLE on that edge.
//    - Its output is registered with q_valid=1 and done=1.
//  - Latency and counter:
//    - Latency: exactly 1 cycle from an accepted bit to the corresponding q.
//    - The counter is $clog2(WIDTH) bits wide and counts 0..WIDTH-1; it never wraps mid-word.
//  - Output pulses:
//    - q_valid=0 on any edge where no bit is accepted. q holds its last value during stalls.
//    - done is high for 1 cycle only.
//  - busy=1 while in PASS or INV (combinational from state).
//  - start while busy: ignored; the bit is treated as the next data bit of the current word.
//  - start=1 with data_valid=0: ignored. The FSM stays in IDLE.
//  - Back-to-back words: start is accepted on the edge right after the last bit.
//    This gives a continuous q_valid stream with no bubble.
//  - Reset mid-word: the word is aborted immediately. No done pulse; next word needs a fresh start.
//  - Zero input: the FSM stays in PASS for the whole word; the result is all zeros.
// CONFIGURATION
//  COMPL_OVF_DETECT_EN defined:
//    - ovf port exists.
//    - ovf=1 with done iff the input was the most negative value 1<<(WIDTH-1),
//      i.e. the last bit was accepted in PASS with data=1.
//    - The result in that case equals the input. ovf resets to 0 and clears after 1 cycle.
//  COMPL_OVF_DETECT_EN undefined:
//    - ovf port and its logic are absent. All other behaviour is identical.
// TESTING
//  1. WIDTH=8, input 0x06, one bit per cycle -> output 0xFA; done on the 8th q_valid; ovf=0.
//  2. Input 0x00 -> output 0x00; input 0xFF -> output 0x01.
//  3. Input 0x80 -> output 0x80; ovf=1 with done (macro defined); port absent otherwise.
//  4. Input 0x35 with data_valid low for 3 cycles after bits 2 and 5 -> output 0xCB;
//     q_valid count=8; no q_valid during stalls.
//  5. Words 0x01 then 0x7F with start on the cycle after the last bit -> outputs 0xFF, 0x81;
//     16 consecutive q_valid; 2 done pulses.
//  6. Reset asserted after bit 3 of 0x0C -> outputs 0 immediately, no done.
//     Then 0x0C with a new start -> 0xF4.
//     Extra start pulse mid-word -> ignored; result unchanged.

Source files
------------

// File: rtl/serial_twos_complementer_if.sv
// Serial two's-complementer handshake bundle.
// COMPL_OVF_DETECT_EN adds the ovf signal to the bundle and both modports.
interface serial_twos_complementer_if;
    logic start;
    logic data_valid;
    logic data;
    logic q;
    logic q_valid;
    logic done;
    logic busy;
`ifdef COMPL_OVF_DETECT_EN
    logic ovf;

    modport master (
        output start, data_valid, data,
        input  q, q_valid, done, busy, ovf
    );

    modport slave (
        input  start, data_valid, data,
        output q, q_valid, done, busy, ovf
    );
`else
    modport master (
        output start, data_valid, data,
        input  q, q_valid, done, busy
    );

    modport slave (
        input  start, data_valid, data,
        output q, q_valid, done, busy
    );
`endif
endinterface

// File: rtl/serial_twos_complementer.sv
// Bit-serial two's complementer: LSB-first in, -x mod 2^WIDTH out, one registered
// result bit per accepted input bit. Bits pass unchanged up to and including the
// first 1, later bits are inverted.
// Optional feature macro: COMPL_OVF_DETECT_EN (ovf flag for the most negative input).
module serial_twos_complementer #(
    parameter int unsigned WIDTH = 8
) (
    input logic                          clk,
    input logic                          reset,
    serial_twos_complementer_if.slave    bus
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StPass, StInv} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            q_q, q_d;
    logic            q_valid_q, q_valid_d;
    logic            done_q, done_d;
`ifdef COMPL_OVF_DETECT_EN
    logic            ovf_q, ovf_d;
`endif

    // State and output registers; reset aborts any word in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            q_q       <= 1'b0;
            q_valid_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef COMPL_OVF_DETECT_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            done_q    <= done_d;
`ifdef COMPL_OVF_DETECT_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    // Next-state: accept a bit, emit pass/inverted copy, track the first 1 and word length.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        q_d       = q_q;
        q_valid_d = 1'b0;
        done_d    = 1'b0;
`ifdef COMPL_OVF_DETECT_EN
        ovf_d     = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start && bus.data_valid) begin
                    q_d       = bus.data;
                    q_valid_d = 1'b1;
                    cnt_d     = CntW'(1);
                    state_d   = bus.data ? StInv : StPass;
                end
            end
            StPass, StInv: begin
                // start is ignored here: the bit simply continues the current word
                if (bus.data_valid) begin
                    q_d       = (state_q == StInv) ? ~bus.data : bus.data;
                    q_valid_d = 1'b1;
                    if (cnt_q == LastCnt) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                        done_d  = 1'b1;
`ifdef COMPL_OVF_DETECT_EN
                        // only 1<<(WIDTH-1) reaches its MSB still in PASS with a 1
                        ovf_d   = (state_q == StPass) && bus.data;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (state_q == StPass && bus.data) begin
                            state_d = StInv;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.q       = q_q;
    assign bus.q_valid = q_valid_q;
    assign bus.done    = done_q;
    assign bus.busy    = (state_q != StIdle);
`ifdef COMPL_OVF_DETECT_EN
    assign bus.ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_serial_twos_complementer.sv
// Scoreboard bench for serial_twos_complementer (WIDTH=8): the driver pushes the
// arithmetic result -x mod 2^W bit by bit, a negedge monitor pops and compares.
module tb_serial_twos_complementer;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    serial_twos_complementer_if bus_if ();

    serial_twos_complementer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic q;
        logic done;
        logic ovf;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int qv_cnt = 0;
    int done_cnt = 0;
    int run = 0;
    int run_max = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented result bit must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            run = 0;
        end else if (bus_if.q_valid) begin
            qv_cnt++;
            run++;
            if (run > run_max) run_max = run;
            if (bus_if.done) done_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_q_valid: got 1 expected 0 at %0t", $time);
            end else begin
                e = sb.pop_front();
                check("q", 32'(bus_if.q), 32'(e.q));
                check("done", 32'(bus_if.done), 32'(e.done));
`ifdef COMPL_OVF_DETECT_EN
                check("ovf", 32'(bus_if.ovf), 32'(e.ovf));
`endif
            end
        end else begin
            run = 0;
            if (bus_if.done) begin
                total++;
                bad++;
                $display("FAIL done_without_q_valid: got 1 expected 0 at %0t", $time);
            end
        end
    end

    // One cycle of stimulus; inputs change 1 time unit after the rising edge.
    task automatic drive(input logic s, input logic dv, input logic d);
        bus_if.start = s;
        bus_if.data_valid = dv;
        bus_if.data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic push_result(input logic [W-1:0] v, input int nbits, input bit full);
        logic [W-1:0] res;
        exp_t e;
        res = -v;
        for (int i = 0; i < nbits; i++) begin
            e.q = res[i];
            e.done = full && (i == W - 1);
            e.ovf = full && (i == W - 1) && (v == (W'(1) << (W - 1)));
            sb.push_back(e);
        end
    endtask

    // noise: 0 none, 1 random start mid-word, 2 start held high mid-word.
    // stall_mask[i]: 3 stall cycles before bit i; rnd_stall adds random stalls.
    task automatic send_word(input logic [W-1:0] v, input int noise,
                             input logic [W-1:0] stall_mask, input bit rnd_stall);
        logic s;
        push_result(v, W, 1'b1);
        for (int i = 0; i < W; i++) begin
            if (i > 0 && stall_mask[i]) begin
                for (int k = 0; k < 3; k++) drive(1'($urandom), 1'b0, 1'($urandom));
            end
            if (i > 0 && rnd_stall && ($urandom_range(0, 3) == 0)) begin
                drive(1'($urandom), 1'b0, 1'($urandom));
            end
            s = (i == 0) ? 1'b1 : (noise == 2) ? 1'b1 : (noise == 1) ? 1'($urandom) : 1'b0;
            drive(s, 1'b1, v[i]);
            if (i == 0) check("busy_after_start", 32'(bus_if.busy), 32'd1);
        end
        check("busy_after_last", 32'(bus_if.busy), 32'd0);
    endtask

    initial begin
        int qv0;
        int d0;
        bus_if.start = 1'b0;
        bus_if.data_valid = 1'b0;
        bus_if.data = 1'b0;
        #2;
        check("reset_q", 32'(bus_if.q), 32'd0);
        check("reset_q_valid", 32'(bus_if.q_valid), 32'd0);
        check("reset_done", 32'(bus_if.done), 32'd0);
        check("reset_busy", 32'(bus_if.busy), 32'd0);
`ifdef COMPL_OVF_DETECT_EN
        check("reset_ovf", 32'(bus_if.ovf), 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0);

        // start without data_valid must not begin a word
        drive(1'b1, 1'b0, 1'b1);
        check("start_no_valid_busy", 32'(bus_if.busy), 32'd0);
        drive(1'b0, 1'b0, 1'b0);

        send_word(8'h06, 0, '0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        send_word(8'h00, 0, '0, 1'b0);
        send_word(8'hFF, 0, '0, 1'b0);
        send_word(8'h80, 0, '0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        // stalls after bits 2 and 5
        qv0 = qv_cnt;
        send_word(8'h35, 0, 8'b0010_0100, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check("stall_q_valid_count", 32'(qv_cnt - qv0), 32'd8);

        // back-to-back words form one unbroken q_valid stream
        drive(1'b0, 1'b0, 1'b0);
        run_max = 0;
        d0 = done_cnt;
        send_word(8'h01, 0, '0, 1'b0);
        send_word(8'h7F, 0, '0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check("b2b_run", 32'(run_max), 32'd16);
        check("b2b_done_count", 32'(done_cnt - d0), 32'd2);

        // abort 0x0C after three bits
        d0 = done_cnt;
        push_result(8'h0C, 3, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_q", 32'(bus_if.q), 32'd0);
        check("abort_q_valid", 32'(bus_if.q_valid), 32'd0);
        check("abort_busy", 32'(bus_if.busy), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b0, 1'b1, 1'b1);
        check("abort_needs_start", 32'(bus_if.busy), 32'd0);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        send_word(8'h0C, 2, '0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        // randomized words: random stalls, spurious starts, optional gaps
        for (int n = 0; n < 60; n++) begin
            logic [W-1:0] v;
            v = W'($urandom);
            if ($urandom_range(0, 7) == 0) v = 8'h80;
            send_word(v, 1, '0, 1'b1);
            if ($urandom_range(0, 1) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                    drive(1'($urandom), 1'b0, 1'($urandom));
                end
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
